// File: rtl/mul_pipe.sv
// Fully pipelined RV32M multiplier: one chunk of the multiplier is consumed per stage,
// results emerge STAGES cycles after issue, and a mispredict squashes everything in flight.
module mul_pipe #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5,
    parameter int STAGES  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          commit_mis_pred,
    input  logic                          issue_valid,
    input  logic [XLEN-1:0]               issue_opa,
    input  logic [XLEN-1:0]               issue_opb,
    input  logic [1:0]                    issue_func,
    input  logic [PRF_LEN-1:0]            issue_prf_idx,
    input  logic [ROB_LEN-1:0]            issue_rob_idx,
    input  logic [XLEN-1:0]               issue_PC,
    output logic                          mul_valid,
    output logic [XLEN-1:0]               mul_value,
    output logic [PRF_LEN-1:0]            mul_prf_idx,
    output logic [ROB_LEN-1:0]            mul_rob_idx,
    output logic [XLEN-1:0]               mul_PC,
    output logic [$clog2(STAGES+1)-1:0]   mul_inflight
);

    localparam int DW   = 2 * XLEN;
    localparam int CW   = DW / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int CNTW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        FUNC_MUL    = 2'b00,
        FUNC_MULH   = 2'b01,
        FUNC_MULHSU = 2'b10,
        FUNC_MULHU  = 2'b11
    } func_e;

    typedef struct packed {
        logic               valid;
        logic [DW-1:0]      mcand;
        logic [DW-1:0]      mplier;   // unconsumed chunks, next chunk in the LSBs
        logic [DW-1:0]      acc;
        func_e              func;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
    } stage_t;

    stage_t issue_st;
    stage_t pipe_q [NREG];
    stage_t cur    [STAGES];
    stage_t adv    [STAGES];

    logic sign_a;
    logic sign_b;

    always_comb begin
        sign_a = issue_opa[XLEN-1] &&
                 ((issue_func == FUNC_MULH) || (issue_func == FUNC_MULHSU));
        sign_b = issue_opb[XLEN-1] && (issue_func == FUNC_MULH);

        issue_st.valid   = issue_valid;
        issue_st.mcand   = {{XLEN{sign_a}}, issue_opa};
        issue_st.mplier  = {{XLEN{sign_b}}, issue_opb};
        issue_st.acc     = '0;
        issue_st.func    = func_e'(issue_func);
        issue_st.prf_idx = issue_prf_idx;
        issue_st.rob_idx = issue_rob_idx;
        issue_st.pc      = issue_PC;
    end

    // Stage k adds mcand * chunk_k, shifted to bit k*CW, into the running product.
    always_comb begin
        // NOTE: every element is given a value on every pass, so no latch can form.
        cur[0] = issue_st;
        for (int k = 1; k < STAGES; k++) begin
            cur[k] = pipe_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            adv[k]        = cur[k];
            adv[k].acc    = cur[k].acc +
                            ((cur[k].mcand * DW'(cur[k].mplier[CW-1:0])) << (k * CW));
            adv[k].mplier = cur[k].mplier >> CW;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || commit_mis_pred) begin
            // NOTE: only the valid bits are cleared; stage data is don't-care while invalid.
            for (int k = 0; k < NREG; k++) begin
                pipe_q[k].valid <= 1'b0;
            end
            mul_valid    <= 1'b0;
            mul_value    <= '0;
            mul_prf_idx  <= '0;
            mul_rob_idx  <= '0;
            mul_PC       <= XLEN'(32'hfacebeec);
            mul_inflight <= '0;
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pipe_q[k] <= adv[k];
            end
            mul_valid    <= adv[STAGES-1].valid;
            mul_value    <= (adv[STAGES-1].func == FUNC_MUL) ? adv[STAGES-1].acc[XLEN-1:0]
                                                             : adv[STAGES-1].acc[DW-1:XLEN];
            mul_prf_idx  <= adv[STAGES-1].prf_idx;
            mul_rob_idx  <= adv[STAGES-1].rob_idx;
            mul_PC       <= adv[STAGES-1].pc;
            // The op sitting in the output register is the one that leaves on this edge.
            mul_inflight <= mul_inflight + CNTW'(issue_valid) - CNTW'(mul_valid);
        end
    end

endmodule
